ram_loader: RTL and testbench

Bus initiator that programs the 16-byte RAM through its existing control interface (load_address, ram_in, ram_out) over the shared 8-bit bus. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive addresses 0..WORDS-1. It holds the CPU off the bus while it runs. It is the writer side of the RAM port and replaces manual DIP-switch programming.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ram_loader.sv | 202 ++++++++++++++++++++
 tb/tb_ram_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side bus agents.
//   state_e    : ram_loader FSM states
//   ram_ctrl_t : RAM control strobe bundle {load_address, ram_in, ram_out}
//   DATA_W     : shared bus / data width
//   ADDR_W     : RAM address width
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    ADDR,
    WRITE,
    VERIFY,
    NEXT,
    DONE
  } state_e;

  typedef struct packed {
    logic load_address;
    logic ram_in;
    logic ram_out;
  } ram_ctrl_t;

endpackage

// File: rtl/ram_loader.sv
// ram_loader: bus initiator that programs the RAM through its control
// interface. It accepts a byte stream over valid/ready and writes the bytes
// to addresses 0..WORDS-1, holding the CPU off the shared bus while it runs.
//
// Optional feature: define RAM_LOADER_VERIFY_EN to add a read-back VERIFY
// cycle after each write; a mismatch sets the sticky error flag and aborts.
//
// Ports:
//   clk          system clock, rising edge
//   clear        asynchronous active-high reset
//   start        begin a load run (sampled only in IDLE)
//   in_data      next byte to program
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle
//   bus_in       bus value, used only for read-back
//   bus_out      value driven onto the bus when bus_en=1
//   bus_en       bus drive enable
//   load_address RAM: latch memory address register from the bus
//   ram_in       RAM: write bus value at current address
//   ram_out      RAM: drive contents onto the bus
//   busy         run in progress; CPU must release the bus
//   done         one-cycle pulse at run completion
//   error        sticky read-back mismatch (0 without the feature)
module ram_loader #(
  parameter int unsigned WORDS  = 16,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_en,
  output logic              load_address,
  output logic              ram_in,
  output logic              ram_out,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Outputs are registered: decoded from the next state and loaded together
  // with it, so every port comes straight from a flop.
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bus_en_q, bus_en_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  ram_ctrl_t         ctrl_q, ctrl_d;

`ifdef RAM_LOADER_VERIFY_EN
  logic error_q, error_d;
`else
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef RAM_LOADER_VERIFY_EN
    error_d = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_DATA;
          addr_d  = '0;
        end
      end
      WAIT_DATA: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          state_d = ADDR;
        end
      end
      ADDR: state_d = WRITE;
      WRITE: begin
`ifdef RAM_LOADER_VERIFY_EN
        state_d = VERIFY;
`else
        state_d = NEXT;
`endif
      end
      VERIFY: begin
`ifdef RAM_LOADER_VERIFY_EN
        if (bus_in != data_q) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = NEXT;
        end
`else
        state_d = IDLE;
`endif
      end
      NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = WAIT_DATA;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    bus_en_d   = 1'b0;
    bus_out_d  = '0;
    ctrl_d     = '0;
    case (state_d)
      WAIT_DATA: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      ADDR: begin
        busy_d              = 1'b1;
        bus_en_d            = 1'b1;
        bus_out_d           = DATA_W'(addr_d);
        ctrl_d.load_address = 1'b1;
      end
      WRITE: begin
        busy_d        = 1'b1;
        bus_en_d      = 1'b1;
        bus_out_d     = data_d;
        ctrl_d.ram_in = 1'b1;
      end
      VERIFY: begin
        busy_d         = 1'b1;
        ctrl_d.ram_out = 1'b1;
      end
      NEXT:    busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_en_q   <= 1'b0;
      bus_out_q  <= '0;
      ctrl_q     <= '0;
`ifdef RAM_LOADER_VERIFY_EN
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_en_q   <= bus_en_d;
      bus_out_q  <= bus_out_d;
      ctrl_q     <= ctrl_d;
`ifdef RAM_LOADER_VERIFY_EN
      error_q    <= error_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bus_en       = bus_en_q;
  assign bus_out      = bus_out_q;
  assign load_address = ctrl_q.load_address;
  assign ram_in       = ctrl_q.ram_in;
  assign ram_out      = ctrl_q.ram_out;
`ifdef RAM_LOADER_VERIFY_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader with a behavioural RAM on the shared bus.
// Expected writes are queued at stimulus time; a monitor pops and compares
// them whenever the loader strobes the RAM.
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
  localparam int CYC = 5;
`else
  localparam int CYC = 4;
`endif

  logic       clk = 1'b0;
  logic       clear, start, in_valid;
  logic [7:0] in_data, bus_in, bus_out;
  logic       in_ready, bus_en, load_address, ram_in, ram_out, busy, done, error;

  ram_loader #(.WORDS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .clear(clear), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_en(bus_en),
    .load_address(load_address), .ram_in(ram_in), .ram_out(ram_out),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [7:0] ram_mem [16];
  logic [3:0] mar = 4'd0;
  logic       corrupt = 1'b0;
  always @(posedge clk) begin
    if (load_address) mar <= bus_out[3:0];
    if (ram_in) ram_mem[mar] <= bus_out;
  end
  assign bus_in = ram_out ? (ram_mem[mar] ^ {7'b0, (corrupt && mar == 4'd2)}) : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  int  start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare every RAM strobe against the scoreboard
  wr_t e;
  always @(negedge clk) begin
    if (load_address || ram_in || ram_out) begin
      total++;
      if ($countones({load_address, ram_in, ram_out}) > 1 || (ram_out && bus_en)) begin
        bad++;
        $display("FAIL strobe_excl: la=%b ri=%b ro=%b en=%b", load_address, ram_in, ram_out, bus_en);
      end
    end
    if (load_address) begin
      total++;
      if (exp_q.size() == 0 || bus_out !== {4'b0, exp_q[0].a} || bus_en !== 1'b1) begin
        bad++;
        $display("FAIL addr_phase: got bus=%h en=%b", bus_out, bus_en);
      end
    end
    if (ram_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%h", mar, bus_out);
      end else begin
        e = exp_q.pop_front();
        if (mar !== e.a || bus_out !== e.d || bus_en !== 1'b1) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h en=%b expected addr=%0d data=%h",
                   mar, bus_out, bus_en, e.a, e.d);
        end
      end
    end
    if (done) done_cnt++;
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back('{a: a, d: d});
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("handshake_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
    cycles = cyc - start_cyc;
  endtask

  int cycles;
  int dc;

  initial begin
    clear = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check("reset_outputs",
          {in_ready, bus_out, bus_en, load_address, ram_in, ram_out, busy, done, error}, 32'd0);
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    // Full load 0x00..0x0F
    dc = done_cnt;
    do_start();
    for (int unsigned i = 0; i < 16; i++) send(4'(i), 8'(i));
    wait_done(cycles);
    check("full_len", cycles, 16 * CYC + 1);
    check("done_busy_low", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("full_done_cnt", done_cnt - dc, 1);
    for (int unsigned i = 0; i < 16; i++) check("full_ram", ram_mem[i], 8'(i));

    // Backpressure before byte 3
    do_start();
    for (int unsigned i = 0; i < 16; i++) begin
      if (i == 3) begin
        repeat (7) @(negedge clk);
        check("bp_in_ready", in_ready, 1);
        check("bp_busy", busy, 1);
      end
      send(4'(i), (i == 3) ? 8'hfe : 8'h10 + 8'(i));
    end
    wait_done(cycles);
    @(negedge clk);
    check("bp_ram3", ram_mem[3], 8'hfe);
    check("bp_ram15", ram_mem[15], 8'h1f);

    // Start pulse while busy is ignored
    dc = done_cnt;
    do_start();
    for (int unsigned i = 0; i < 16; i++) begin
      if (i == 5) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send(4'(i), 8'ha0 + 8'(i));
    end
    wait_done(cycles);
    check("sb_len", cycles, 16 * CYC + 1);
    repeat (3) @(negedge clk);
    check("sb_done_cnt", done_cnt - dc, 1);
    check("sb_idle", busy, 0);
    for (int unsigned i = 0; i < 16; i++) check("sb_ram", ram_mem[i], 8'ha0 + 8'(i));

    // Clear during WRITE of addr 6
    do_start();
    for (int unsigned i = 0; i < 7; i++) send(4'(i), 8'h50 + 8'(i));
    @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check("clr_bus_en", bus_en, 0);
    check("clr_ram_in", ram_in, 0);
    check("clr_busy", busy, 0);
    check("clr_pending", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 16; i++)
      check("clr_ram", ram_mem[i], (i < 6) ? 8'h50 + 8'(i) : 8'ha0 + 8'(i));

    // Reload from 0 after the abort
    do_start();
    for (int unsigned i = 0; i < 16; i++) send(4'(i), 8'hc0 + 8'(i));
    wait_done(cycles);
    check("reload_len", cycles, 16 * CYC + 1);
    @(negedge clk);
    for (int unsigned i = 0; i < 16; i++) check("reload_ram", ram_mem[i], 8'hc0 + 8'(i));
    check("error_clean", error, 0);

`ifdef RAM_LOADER_VERIFY_EN
    // Read-back mismatch at addr 2 aborts the run
    corrupt = 1'b1;
    dc = done_cnt;
    do_start();
    for (int unsigned i = 0; i < 3; i++) send(4'(i), 8'h70 + 8'(i));
    wait_done(cycles);
    check("vf_error", error, 1);
    check("vf_len", cycles, 3 * CYC);
    repeat (5) @(negedge clk);
    corrupt = 1'b0;
    check("vf_done_cnt", done_cnt - dc, 1);
    check("vf_ram3", ram_mem[3], 8'hc3);
    check("vf_sticky", error, 1);
    check("vf_idle", in_ready, 0);
    clear = 1'b1;
    #1;
    check("vf_clear", error, 0);
    @(negedge clk);
    clear = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
